// File: rtl/i2c_pkg.sv
// Shared I2C slave types: FSM states, bus event bundle, bit constants.
// Imported by the sync front-end, the interface users and the top.
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WR_DATA,
    ST_WR_ACK,
    ST_RD_DATA,
    ST_RD_ACK,
    ST_IGNORE
  } i2c_state_t;

  typedef struct packed {
    logic scl_rise;
    logic scl_fall;
    logic start;
    logic stop;
    logic sda;
  } i2c_ev_t;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;
  localparam logic I2C_WR   = 1'b0;
  localparam logic I2C_RD   = 1'b1;

  localparam logic [6:0] I2C_DEF_ADDR = 7'h50;

endpackage

// File: rtl/i2c_regif_slave_if.sv
// Pad + REG_BL side bundle of the I2C register slave.
// slave: DUT view; master: pads/register-block view.
interface i2c_regif_slave_if;
  logic       scl_i;
  logic       sda_i;
  logic       sda_oe;
  logic       we;
  logic [7:0] DI;
  logic [7:0] Adr_wr;
  logic [7:0] Adr_rd;
  logic [7:0] dat_REG;
  logic       busy;

  modport slave (
    input  scl_i, sda_i, dat_REG,
    output sda_oe, we, DI, Adr_wr, Adr_rd, busy
  );

  modport master (
    output scl_i, sda_i, dat_REG,
    input  sda_oe, we, DI, Adr_wr, Adr_rd, busy
  );
endinterface

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchronizers with registered edge, START and STOP pulses.
// In: clk, rst_n, scl_i, sda_i. Out: ev (pulses + aligned SDA level).
module i2c_bus_sync
  import i2c_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    scl_i,
  input  logic    sda_i,
  output i2c_ev_t ev
);

  logic [SYNC_STAGES-1:0] scl_sr;
  logic [SYNC_STAGES-1:0] sda_sr;
  logic scl_s, sda_s;
  logic scl_q, sda_q;

  assign scl_s = scl_sr[SYNC_STAGES-1];
  assign sda_s = sda_sr[SYNC_STAGES-1];

  // Idle bus is high: reset to 1 so release
  // of reset never fakes an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sr <= '1;
      sda_sr <= '1;
      scl_q  <= 1'b1;
      sda_q  <= 1'b1;
      ev     <= '0;
      ev.sda <= 1'b1;
    end else begin
      scl_sr <= {scl_sr[SYNC_STAGES-2:0], scl_i};
      sda_sr <= {sda_sr[SYNC_STAGES-2:0], sda_i};
      scl_q  <= scl_s;
      sda_q  <= sda_s;
      ev.scl_rise <= scl_s & ~scl_q;
      ev.scl_fall <= ~scl_s & scl_q;
      ev.start    <= scl_s & scl_q & sda_q & ~sda_s;
      ev.stop     <= scl_s & scl_q & ~sda_q & sda_s;
      ev.sda      <= sda_s;
    end
  end

endmodule

// File: rtl/i2c_regif_slave.sv
// I2C slave mapping bus transfers onto a 256x8 register block.
// Ports: clk, rst_n, bus (scl/sda pads, REG_BL write/read, busy).
module i2c_regif_slave
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR  = I2C_DEF_ADDR,
  parameter int         SYNC_STAGES = 2
) (
  input logic              clk,
  input logic              rst_n,
  i2c_regif_slave_if.slave bus
);

  i2c_ev_t    ev;
  i2c_state_t state;
  logic [7:0] shreg;
  logic [7:0] ptr;
  logic [7:0] adr_wr_q;
  logic [7:0] di_q;
  logic [2:0] bit_cnt;
  logic       we_q;
  logic       sda_oe_q;
  logic       busy_q;
  logic [7:0] rx_byte;
  logic       last_bit;

  i2c_bus_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .scl_i(bus.scl_i),
    .sda_i(bus.sda_i),
    .ev   (ev)
  );

  assign rx_byte  = {shreg[6:0], ev.sda};
  assign last_bit = (bit_cnt == 3'd7);

  assign bus.sda_oe = sda_oe_q;
  assign bus.we     = we_q;
  assign bus.DI     = di_q;
  assign bus.Adr_wr = adr_wr_q;
  assign bus.Adr_rd = ptr;
  assign bus.busy   = busy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      shreg    <= '0;
      bit_cnt  <= '0;
      ptr      <= '0;
      adr_wr_q <= '0;
      di_q     <= '0;
      we_q     <= 1'b0;
      sda_oe_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      we_q <= 1'b0;
      // Post-write increment, one clk after the strobe.
      if (we_q) ptr <= ptr + 8'd1;
      if (ev.stop) begin
        state    <= ST_IDLE;
        sda_oe_q <= 1'b0;
        busy_q   <= 1'b0;
      end else if (ev.start) begin
        state    <= ST_ADDR;
        bit_cnt  <= '0;
        sda_oe_q <= 1'b0;
      end else if (ev.scl_rise) begin
        unique case (state)
          ST_ADDR: begin
            shreg   <= rx_byte;
            bit_cnt <= bit_cnt + 3'd1;
            if (last_bit) begin
              if (rx_byte[7:1] == SLAVE_ADDR) begin
                state  <= ST_ADDR_ACK;
                busy_q <= 1'b1;
              end else begin
                state  <= ST_IGNORE;
                busy_q <= 1'b0;
              end
            end
          end
          ST_PTR: begin
            shreg   <= rx_byte;
            bit_cnt <= bit_cnt + 3'd1;
            if (last_bit) begin
              ptr   <= rx_byte;
              state <= ST_PTR_ACK;
            end
          end
          ST_WR_DATA: begin
            shreg   <= rx_byte;
            bit_cnt <= bit_cnt + 3'd1;
            if (last_bit) begin
              we_q     <= 1'b1;
              adr_wr_q <= ptr;
              di_q     <= rx_byte;
              state    <= ST_WR_ACK;
            end
          end
          ST_RD_ACK: begin
            if (ev.sda == I2C_NACK) state <= ST_IGNORE;
          end
          default: ;
        endcase
      end else if (ev.scl_fall) begin
        unique case (state)
          // bit_cnt 0: 8th fall, drive ACK.
          // bit_cnt 1: 9th fall, release and move on.
          ST_ADDR_ACK, ST_PTR_ACK, ST_WR_ACK: begin
            if (bit_cnt == 3'd0) begin
              sda_oe_q <= ~I2C_ACK;
              bit_cnt  <= 3'd1;
            end else begin
              sda_oe_q <= 1'b0;
              bit_cnt  <= 3'd0;
              if (state != ST_ADDR_ACK) begin
                state <= ST_WR_DATA;
              end else if (shreg[0] == I2C_WR) begin
                state <= ST_PTR;
              end else begin
                shreg    <= bus.dat_REG;
                ptr      <= ptr + 8'd1;
                sda_oe_q <= ~bus.dat_REG[7];
                state    <= ST_RD_DATA;
              end
            end
          end
          ST_RD_DATA: begin
            if (last_bit) begin
              sda_oe_q <= 1'b0;
              bit_cnt  <= 3'd0;
              state    <= ST_RD_ACK;
            end else begin
              sda_oe_q <= ~shreg[6];
              shreg    <= {shreg[6:0], 1'b0};
              bit_cnt  <= bit_cnt + 3'd1;
            end
          end
          // Only reached after a master ACK.
          ST_RD_ACK: begin
            shreg    <= bus.dat_REG;
            ptr      <= ptr + 8'd1;
            sda_oe_q <= ~bus.dat_REG[7];
            bit_cnt  <= 3'd0;
            state    <= ST_RD_DATA;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
